// File: rtl/sprite_ram_arbiter_pkg.sv
// Shared types and constants for the sprite RAM arbiter.
package sprite_arb_pkg;

   localparam int SPR_ADDR_W   = 10;
   localparam int SPR_DATA_W   = 24;
   localparam int SPR_MAX_WAIT = 8;

   // Owner of the read issued in the previous cycle.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_DRAW = 2'd1,
      OWN_COL  = 2'd2
   } owner_t;

   // ARB: normal arbitration; LD_LOCK: loader mid-burst keeps precedence over collision.
   typedef enum logic {
      ARB     = 1'b0,
      LD_LOCK = 1'b1
   } arb_state_t;

   // Encodes the read winner of this cycle as the tag captured for next cycle's return.
   function automatic owner_t owner_of(input logic draw_win, input logic col_win);
      owner_t own;
      own = OWN_NONE;
      if (draw_win) begin
         own = OWN_DRAW;
      end else if (col_win) begin
         own = OWN_COL;
      end
      return own;
   endfunction

endpackage

// File: rtl/sprite_ram_arbiter_rr_pick.sv
// Two-way round-robin picker between the collision reader and the loader.
// last_col remembers which of the two was granted most recently; the other
// one wins the next tie. Reset leaves collision as the next winner.
module sprite_rr_pick (
   input  logic clk,
   input  logic rst_n,
   input  logic col_elig,
   input  logic ld_elig,
   input  logic col_win,
   input  logic ld_win,
   output logic pick_col,
   output logic pick_ld
);

   logic last_col;

   // Record the most recent collision/loader grant, whichever arbiter state issued it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_col <= 1'b0;
      end else if (col_win) begin
         last_col <= 1'b1;
      end else if (ld_win) begin
         last_col <= 1'b0;
      end
   end

   // Tie goes to whoever was not granted last; a lone eligible client always wins.
   always_comb begin
      pick_col = 1'b0;
      pick_ld  = 1'b0;
      if (col_elig && ld_elig) begin
         pick_col = !last_col;
         pick_ld  = last_col;
      end else begin
         pick_col = col_elig;
         pick_ld  = ld_elig;
      end
   end

endmodule

// File: rtl/sprite_ram_arbiter.sv
// Sprite RAM arbiter: shares one 1-cycle-latency RAM between the draw
// pipeline (read), the collision checker (read) and the sprite loader
// (write, vblank only). One access per cycle; read data is routed back to
// its owner one cycle after the grant.
//
// Handshake (all three clients): a transfer happens in a cycle where req and
// gnt are both high. A client holds req and its address/data stable until it
// sees gnt. gnt is combinational, at most one is high, and all are forced low
// while Reset is low.
module sprite_ram_arbiter
   import sprite_arb_pkg::*;
#(
   parameter int ADDR_W   = SPR_ADDR_W,
   parameter int DATA_W   = SPR_DATA_W,
   parameter int MAX_WAIT = SPR_MAX_WAIT
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              vblank,
   input  logic              draw_req,
   input  logic [ADDR_W-1:0] draw_addr,
   output logic              draw_gnt,
   output logic              draw_rvalid,
   output logic [DATA_W-1:0] draw_rdata,
   input  logic              col_req,
   input  logic [ADDR_W-1:0] col_addr,
   output logic              col_gnt,
   output logic              col_rvalid,
   output logic [DATA_W-1:0] col_rdata,
   input  logic              ld_req,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   output logic              ld_gnt,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_waddr,
   output logic [ADDR_W-1:0] ram_raddr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output arb_state_t        arb_state
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

   arb_state_t        state;
   owner_t            tag;
   logic [WAIT_W-1:0] wait_cnt;
   logic              starved;
   logic              ld_ok;
   logic              rr_col;
   logic              rr_ld;

   // Collision has waited long enough to preempt draw once.
   assign starved = col_req && (wait_cnt == WAIT_MAX);
   // The loader may only write during vertical blanking.
   assign ld_ok   = ld_req && vblank;

   sprite_rr_pick u_rr (
      .clk      (Clk),
      .rst_n    (Reset),
      .col_elig (col_req),
      .ld_elig  (ld_ok),
      .col_win  (col_gnt),
      .ld_win   (ld_gnt),
      .pick_col (rr_col),
      .pick_ld  (rr_ld)
   );

   // Grant selection: starved collision, then draw, then either the burst
   // lock (loader ahead of collision) or the round-robin pick.
   always_comb begin
      draw_gnt = 1'b0;
      col_gnt  = 1'b0;
      ld_gnt   = 1'b0;
      if (Reset) begin
         if (starved) begin
            col_gnt = 1'b1;
         end else if (draw_req) begin
            draw_gnt = 1'b1;
         end else if (state == LD_LOCK) begin
            if (ld_ok) begin
               ld_gnt = 1'b1;
            end else if (col_req) begin
               col_gnt = 1'b1;
            end
         end else begin
            col_gnt = rr_col;
            ld_gnt  = rr_ld;
         end
      end
   end

   // RAM port drive: read address follows collision only when it wins,
   // otherwise it rests on the draw address; write port carries the loader word.
   always_comb begin
      ram_raddr = col_gnt ? col_addr : draw_addr;
      ram_we    = ld_gnt;
      ram_waddr = ld_addr;
      ram_wdata = ld_data;
   end

   // Burst lock: enter on a non-final loader word, leave on the final word or
   // as soon as vblank drops (the rest of the burst resumes later).
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state <= ARB;
      end else begin
         case (state)
            ARB: begin
               if (ld_gnt && !ld_last) begin
                  state <= LD_LOCK;
               end
            end
            LD_LOCK: begin
               if (ld_gnt && ld_last) begin
                  state <= ARB;
               end else if (!vblank) begin
                  state <= ARB;
               end
            end
            default: state <= ARB;
         endcase
      end
   end

   // Starvation counter for the collision reader; saturates, clears on grant or withdrawal.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         wait_cnt <= '0;
      end else if (col_gnt || !col_req) begin
         wait_cnt <= '0;
      end else if (wait_cnt != WAIT_MAX) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // Owner tag of the read issued this cycle; reset drops any read in flight.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         tag <= OWN_NONE;
      end else begin
         tag <= owner_of(draw_gnt, col_gnt);
      end
   end

   // Return path: data always mirrors the RAM, valid goes only to the tagged owner.
   always_comb begin
      draw_rdata  = ram_rdata;
      col_rdata   = ram_rdata;
      draw_rvalid = (tag == OWN_DRAW);
      col_rvalid  = (tag == OWN_COL);
      arb_state   = state;
   end

endmodule

// File: tb/tb_sprite_ram_arbiter.sv
// Self-checking bench for sprite_ram_arbiter: directed scenarios with literal
// expectations plus randomized traffic, all checked against a behavioural model.
module tb_sprite_ram_arbiter;
   import sprite_arb_pkg::*;

   localparam int AW = 10;
   localparam int DW = 24;
   localparam int MW = 8;

   // ---------------- clock / reset ----------------
   logic Clk = 1'b0;
   logic Reset;
   always #5 Clk = ~Clk;

   logic          vblank;
   logic          draw_req, col_req, ld_req, ld_last;
   logic [AW-1:0] draw_addr, col_addr, ld_addr;
   logic [DW-1:0] ld_data;
   logic          draw_gnt, col_gnt, ld_gnt;
   logic          draw_rvalid, col_rvalid;
   logic [DW-1:0] draw_rdata, col_rdata;
   logic          ram_we;
   logic [AW-1:0] ram_waddr, ram_raddr;
   logic [DW-1:0] ram_wdata, ram_rdata;
   arb_state_t    arb_state;

   sprite_ram_arbiter dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .vblank      (vblank),
      .draw_req    (draw_req),
      .draw_addr   (draw_addr),
      .draw_gnt    (draw_gnt),
      .draw_rvalid (draw_rvalid),
      .draw_rdata  (draw_rdata),
      .col_req     (col_req),
      .col_addr    (col_addr),
      .col_gnt     (col_gnt),
      .col_rvalid  (col_rvalid),
      .col_rdata   (col_rdata),
      .ld_req      (ld_req),
      .ld_addr     (ld_addr),
      .ld_data     (ld_data),
      .ld_last     (ld_last),
      .ld_gnt      (ld_gnt),
      .ram_we      (ram_we),
      .ram_waddr   (ram_waddr),
      .ram_raddr   (ram_raddr),
      .ram_wdata   (ram_wdata),
      .ram_rdata   (ram_rdata),
      .arb_state   (arb_state)
   );

   // ---------------- sprite RAM (environment) ----------------
   logic [DW-1:0] ram_mem [1024];
   always @(posedge Clk) begin
      if (ram_we) ram_mem[ram_waddr] <= ram_wdata;
      ram_rdata <= ram_mem[ram_raddr];
   end

   // ---------------- scoreboard ----------------
   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic          is_col;
      logic [DW-1:0] data;
   } ret_t;
   ret_t          exp_q[$];
   logic [DW-1:0] model_mem [1024];
   bit            m_lock;
   bit            m_last_col;
   int            m_wait;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: every cycle, decide from the priority rules who must be
   // granted, what must come back this cycle, and compare with the DUT.
   initial begin : compare_proc
      bit   e_draw, e_col, e_ld, ce, le, starved;
      ret_t r;
      bit   have_ret;
      m_lock = 0; m_last_col = 0; m_wait = 0;
      forever begin
         @(negedge Clk);
         if (!Reset) begin
            check("rst_gnt", 32'({draw_gnt, col_gnt, ld_gnt}), 32'(0));
            check("rst_we", 32'(ram_we), 32'(0));
            check("rst_rvalid", 32'({draw_rvalid, col_rvalid}), 32'(0));
            m_lock = 0; m_last_col = 0; m_wait = 0;
            exp_q.delete();
         end else begin
            e_draw = 0; e_col = 0; e_ld = 0;
            starved = col_req && (m_wait == MW);
            if (starved) e_col = 1;
            else if (draw_req) e_draw = 1;
            else if (m_lock) begin
               if (ld_req && vblank) e_ld = 1;
               else if (col_req) e_col = 1;
            end else begin
               ce = col_req;
               le = ld_req && vblank;
               if (ce && le) begin
                  if (m_last_col) e_ld = 1; else e_col = 1;
               end else begin
                  e_col = ce; e_ld = le;
               end
            end
            check("gnt", 32'({draw_gnt, col_gnt, ld_gnt}), 32'({e_draw, e_col, e_ld}));
            check("ram_we", 32'(ram_we), 32'(e_ld));
            if (e_ld) begin
               check("ram_waddr", 32'(ram_waddr), 32'(ld_addr));
               check("ram_wdata", 32'(ram_wdata), 32'(ld_data));
            end else begin
               check("ram_raddr", 32'(ram_raddr), 32'(e_col ? col_addr : draw_addr));
            end
            check("arb_state", 32'(arb_state), 32'(m_lock ? LD_LOCK : ARB));
            have_ret = (exp_q.size() > 0);
            if (have_ret) r = exp_q.pop_front();
            check("rvalid", 32'({draw_rvalid, col_rvalid}),
                  32'({have_ret && !r.is_col, have_ret && r.is_col}));
            if (have_ret && !r.is_col) check("draw_rdata", 32'(draw_rdata), 32'(r.data));
            if (have_ret && r.is_col) check("col_rdata", 32'(col_rdata), 32'(r.data));
            // advance model to the next cycle
            if (e_draw) exp_q.push_back('{is_col: 1'b0, data: model_mem[draw_addr]});
            if (e_col) exp_q.push_back('{is_col: 1'b1, data: model_mem[col_addr]});
            if (e_ld) model_mem[ld_addr] = ld_data;
            if (e_col || !col_req) m_wait = 0;
            else if (m_wait < MW) m_wait++;
            if (e_col) m_last_col = 1;
            else if (e_ld) m_last_col = 0;
            if (!m_lock) m_lock = e_ld && !ld_last;
            else if ((e_ld && ld_last) || !vblank) m_lock = 0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // Draw reads base..base+3 back to back; expects data dbase..dbase+3.
   task automatic draw_read_seq(input logic [AW-1:0] base, input logic [DW-1:0] dbase);
      for (int i = 0; i < 5; i++) begin
         if (i < 4) begin
            draw_req  = 1'b1;
            draw_addr = base + AW'(i);
         end else begin
            draw_req = 1'b0;
         end
         @(negedge Clk);
         if (i < 4) check("seq_draw_gnt", 32'(draw_gnt), 32'(1));
         if (i > 0) begin
            check("seq_draw_rvalid", 32'(draw_rvalid), 32'(1));
            check("seq_draw_rdata", 32'(draw_rdata), 32'(dbase + DW'(i - 1)));
         end
         step();
      end
   endtask

   task automatic ld_present(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic last);
      ld_req = 1'b1; ld_addr = a; ld_data = d; ld_last = last;
   endtask

   // ---------------- main sequence ----------------
   initial begin : main_proc
      int  first_k;
      bit  d_pend, c_pend, l_pend, d_got, c_got, l_got;
      for (int i = 0; i < 1024; i++) begin
         ram_mem[i]   = DW'(i);
         model_mem[i] = DW'(i);
      end
      vblank = 0; draw_req = 0; col_req = 0; ld_req = 0; ld_last = 0;
      draw_addr = '0; col_addr = '0; ld_addr = '0; ld_data = '0;
      Reset = 1'b1;
      #2 Reset = 1'b0;
      repeat (3) @(posedge Clk);
      #1 Reset = 1'b1;

      // reset state
      @(negedge Clk);
      check("init_gnt", 32'({draw_gnt, col_gnt, ld_gnt}), 32'(0));
      check("init_rvalid", 32'({draw_rvalid, col_rvalid}), 32'(0));
      check("init_state", 32'(arb_state), 32'(ARB));
      step();

      // A: draw reads 0..3, RAM word = address
      draw_read_seq(10'h000, 24'h000000);

      // B: draw and collision both requesting; collision wins on its 9th cycle
      draw_req = 1; draw_addr = 10'h020; col_req = 1; col_addr = 10'h010;
      first_k = 0;
      for (int k = 1; k <= 12 && first_k == 0; k++) begin
         @(negedge Clk);
         if (col_gnt) begin
            first_k = k;
            check("b_draw_blocked", 32'(draw_gnt), 32'(0));
         end else begin
            step();
         end
      end
      check("b_col_cycle", 32'(first_k), 32'(9));
      step();
      col_req = 0;
      @(negedge Clk);
      check("b_col_rvalid", 32'(col_rvalid), 32'(1));
      check("b_col_rdata", 32'(col_rdata), 32'(24'h000010));
      check("b_draw_back", 32'(draw_gnt), 32'(1));
      step();
      draw_req = 0;

      // C: loader burst of 4 words at 0x3FC..0x3FF during vblank
      vblank = 1;
      for (int i = 0; i < 4; i++) begin
         ld_present(10'h3FC + AW'(i), 24'hC0FFE0 + DW'(i), i == 3);
         @(negedge Clk);
         check("c_ld_gnt", 32'(ld_gnt), 32'(1));
         check("c_waddr", 32'(ram_waddr), 32'(10'h3FC + AW'(i)));
         check("c_wdata", 32'(ram_wdata), 32'(24'hC0FFE0 + DW'(i)));
         check("c_state", 32'(arb_state), 32'(i == 0 ? ARB : LD_LOCK));
         step();
      end
      ld_req = 0; ld_last = 0;
      @(negedge Clk);
      check("c_state_end", 32'(arb_state), 32'(ARB));
      step();
      draw_read_seq(10'h3FC, 24'hC0FFE0);

      // D: vblank drops after two of four burst words
      for (int i = 0; i < 2; i++) begin
         ld_present(10'h100 + AW'(i), 24'hB00000 + DW'(i), 1'b0);
         @(negedge Clk);
         check("d_ld_gnt", 32'(ld_gnt), 32'(1));
         step();
      end
      ld_present(10'h102, 24'hB00002, 1'b0);
      vblank = 0;
      for (int j = 0; j < 4; j++) begin
         @(negedge Clk);
         check("d_ld_blocked", 32'(ld_gnt), 32'(0));
         check("d_state", 32'(arb_state), 32'(j == 0 ? LD_LOCK : ARB));
         step();
      end
      vblank = 1;
      @(negedge Clk);
      check("d_resume_gnt", 32'(ld_gnt), 32'(1));
      step();
      ld_present(10'h103, 24'hB00003, 1'b1);
      @(negedge Clk);
      check("d_last_gnt", 32'(ld_gnt), 32'(1));
      check("d_last_state", 32'(arb_state), 32'(LD_LOCK));
      step();
      ld_req = 0; ld_last = 0;
      @(negedge Clk);
      check("d_state_end", 32'(arb_state), 32'(ARB));
      step();
      draw_read_seq(10'h100, 24'hB00000);

      // E: collision and loader both held, no draw: alternate col, ld, col, ld
      col_req = 1; col_addr = 10'h030;
      ld_present(10'h200, 24'h123456, 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(negedge Clk);
         check("e_col_gnt", 32'(col_gnt), 32'(i % 2 == 0));
         check("e_ld_gnt", 32'(ld_gnt), 32'(i % 2 == 1));
         step();
      end
      col_req = 0; ld_req = 0; ld_last = 0;
      step();

      // F: reset the cycle after a draw grant
      draw_req = 1; draw_addr = 10'h005;
      @(negedge Clk);
      check("f_draw_gnt", 32'(draw_gnt), 32'(1));
      step();
      Reset = 0; col_req = 1; ld_present(10'h050, 24'h777777, 1'b1);
      for (int j = 0; j < 3; j++) begin
         @(negedge Clk);
         check("f_no_rvalid", 32'({draw_rvalid, col_rvalid}), 32'(0));
         check("f_no_gnt", 32'({draw_gnt, col_gnt, ld_gnt, ram_we}), 32'(0));
         step();
      end
      Reset = 1; draw_addr = 10'h007; col_req = 0; ld_req = 0; ld_last = 0;
      @(negedge Clk);
      check("f_first_gnt", 32'(draw_gnt), 32'(1));
      step();
      draw_req = 0;
      @(negedge Clk);
      check("f_rvalid", 32'(draw_rvalid), 32'(1));
      check("f_rdata", 32'(draw_rdata), 32'(24'h000007));
      step();

      // R: randomized traffic obeying the hold-until-granted handshake
      d_pend = 0; c_pend = 0; l_pend = 0; d_got = 0; c_got = 0; l_got = 0;
      for (int n = 0; n < 3000; n++) begin
         if (d_got) d_pend = 0;
         if (c_got) c_pend = 0;
         if (l_got) l_pend = 0;
         if (!d_pend && $urandom_range(0, 99) < 40) begin
            d_pend = 1; draw_addr = AW'($urandom_range(0, 63));
         end
         if (!c_pend && $urandom_range(0, 99) < 35) begin
            c_pend = 1; col_addr = AW'($urandom_range(0, 63));
         end
         if (!l_pend && $urandom_range(0, 99) < 35) begin
            l_pend  = 1;
            ld_addr = AW'($urandom_range(0, 63));
            ld_data = DW'($urandom);
            ld_last = ($urandom_range(0, 3) == 0);
         end
         draw_req = d_pend; col_req = c_pend; ld_req = l_pend;
         if ($urandom_range(0, 31) == 0) vblank = ~vblank;
         @(negedge Clk);
         d_got = draw_gnt; c_got = col_gnt; l_got = ld_gnt;
         step();
      end
      draw_req = 0; col_req = 0; ld_req = 0;
      repeat (3) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global bound on run time.
   initial begin : watchdog
      #1000000;
      failures++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
